// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one operand bit per clock, LSB first, giving an exact magnitude/sign/overflow result.
// Define SERIAL_ADD_SUB_SEG_EN to add active-low seven-segment outputs (seg, sign_seg) decoded from mag/neg.
module serial_add_sub #(
   parameter int WIDTH  = 4,
   parameter int SIGNED = 0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            sub,
   input  logic [WIDTH-1:0]                a,
   input  logic [WIDTH-1:0]                b,
   output logic                            busy,
   output logic                            done,
   output logic [WIDTH:0]                  mag,
   output logic                            neg,
   output logic                            ovf
`ifdef SERIAL_ADD_SUB_SEG_EN
   ,
   output logic [7*((WIDTH+4)/4)-1:0]      seg,
   output logic [6:0]                      sign_seg
`endif
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   typedef struct packed {
      logic           neg;
      logic [WIDTH:0] mag;
      logic           ovf;
   } result_t;

   // {carry, sum} of a single full-adder cell
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      logic s;
      logic co;
      s  = x ^ y ^ ci;
      co = (x & y) | (x & ci) | (y & ci);
      return {co, s};
   endfunction

   // Turns the serial sum plus its two top carries into the exact (WIDTH+1)-bit result.
   function automatic result_t fix_result(input logic [WIDTH-1:0] raw,
                                          input logic             cout,
                                          input logic             cmsb,
                                          input logic             is_sub);
      result_t        r;
      logic [WIDTH:0] exact;
      if (SIGNED != 0) begin
         r.ovf = cmsb ^ cout;
         // true sign is the WIDTH-bit sum sign corrected by overflow
         exact = {raw[WIDTH-1] ^ r.ovf, raw};
         r.neg = exact[WIDTH];
      end else if (!is_sub) begin
         r.ovf = cout;
         exact = {cout, raw};
         r.neg = 1'b0;
      end else begin
         // no carry out means a borrow: result is raw - 2^WIDTH
         r.ovf = ~cout;
         exact = {~cout, raw};
         r.neg = ~cout;
      end
      r.mag = r.neg ? (-exact) : exact;
      return r;
   endfunction

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               sub_q, sub_d;
   logic               c_q, c_d;
   logic               cmsb_q, cmsb_d;
   logic [WIDTH-1:0]   raw_q, raw_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH:0]     mag_q, mag_d;
   logic               neg_q, neg_d;
   logic               ovf_q, ovf_d;

   logic [1:0]         fa;
   result_t            res;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      c_d     = c_q;
      cmsb_d  = cmsb_q;
      raw_d   = raw_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      mag_d   = mag_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      fa      = full_add(a_q[0], b_q[0], c_q);
      res     = fix_result(raw_q, c_q, cmsb_q, sub_q);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               sub_d   = sub;
               c_d     = sub;
               cmsb_d  = 1'b0;
               raw_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            raw_d = {fa[0], raw_q[WIDTH-1:1]};
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            c_d   = fa[1];
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               cmsb_d  = c_q;
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FIX: begin
            mag_d   = res.mag;
            neg_d   = res.neg;
            ovf_d   = res.ovf;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         c_q     <= 1'b0;
         cmsb_q  <= 1'b0;
         raw_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mag_q   <= '0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         c_q     <= c_d;
         cmsb_q  <= cmsb_d;
         raw_q   <= raw_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         mag_q   <= mag_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign mag  = mag_q;
   assign neg  = neg_q;
   assign ovf  = ovf_q;

`ifdef SERIAL_ADD_SUB_SEG_EN
   localparam int NDIG = (WIDTH + 4) / 4;

   function automatic logic [6:0] hex7(input logic [3:0] d);
      case (d)
         4'h0:    return 7'h40;
         4'h1:    return 7'h79;
         4'h2:    return 7'h24;
         4'h3:    return 7'h30;
         4'h4:    return 7'h19;
         4'h5:    return 7'h12;
         4'h6:    return 7'h02;
         4'h7:    return 7'h78;
         4'h8:    return 7'h00;
         4'h9:    return 7'h10;
         4'hA:    return 7'h08;
         4'hB:    return 7'h03;
         4'hC:    return 7'h46;
         4'hD:    return 7'h21;
         4'hE:    return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   logic [4*NDIG-1:0] mag_pad;

   always_comb begin
      mag_pad          = '0;
      mag_pad[WIDTH:0] = mag_q;
      for (int i = 0; i < NDIG; i++) begin
         seg[7*i +: 7] = hex7(mag_pad[4*i +: 4]);
      end
   end

   assign sign_seg = neg_q ? 7'h3F : 7'h7F;
`endif

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 Parameter SIGNED, default 0; 0 = operands unsigned, 1 = operands two's complement.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 sub  input  1  0 = a+b, 1 = a-b; latched with start.
REQ-007 a  input  WIDTH  first operand; latched with start.
REQ-008 b  input  WIDTH  second operand; latched with start.
REQ-009 busy  output  1  high in CALC and FIX.
REQ-010 done  output  1  one-cycle pulse when results update.
REQ-011 mag  output  WIDTH+1  magnitude of exact result.
REQ-012 neg  output  1  exact result negative.
REQ-013 ovf  output  1  exact result not representable in WIDTH bits of the selected format.
REQ-014 seg  output  7*NDIG  (SERIAL_ADD_SUB_SEG_EN only) active-low hex digits of mag, NDIG = ceil((WIDTH+1)/4), digit 0 in bits [6:0]; bit order gfedcba.
REQ-015 sign_seg  output  7  (SERIAL_ADD_SUB_SEG_EN only) active-low sign digit.

Function
REQ-016 FSM states IDLE, CALC, FIX; IDLE -> CALC on start=1; CALC -> FIX after WIDTH cycles; FIX -> IDLE unconditionally.
REQ-017 On accepting start: latch a, sub, b XOR {WIDTH{sub}}; carry register = sub; bit counter = 0.
REQ-018 CALC: one bit per cycle, LSB first: sum = a_i ^ b'_i ^ c; carry = majority(a_i, b'_i, c); sum shifted into raw register; carry into MSB also retained.
REQ-019 FIX: form exact (WIDTH+1)-bit result; unsigned: add = {cout, raw}, sub = raw with borrow = ~cout; signed: sign-extended a +/- b.
REQ-020 FIX: neg = exact result < 0; mag = |exact|; ovf: unsigned add = cout, unsigned sub = ~cout, signed = carry-into-MSB XOR cout.
REQ-021 mag, neg, ovf and done register at the FIX edge; done=1 exactly one cycle; latency start-sample edge to done high = WIDTH+1 clocks.
REQ-022 mag/neg/ovf hold until next FIX; a, b, sub changes after acceptance have no effect.
REQ-023 start while busy ignored, no queueing; start in the cycle done=1 (FSM in IDLE) accepted.
REQ-024 Zero results: a-b with a=b gives mag=0, neg=0, ovf=0.

Reset
REQ-025 rst_n=0 forces immediately, independent of clk: state IDLE, busy=0, done=0, mag=0, neg=0, ovf=0, counter/carry/raw=0.
REQ-026 Reset during CALC or FIX aborts; no done pulse; first start after release behaves per REQ-017.

Configuration
REQ-027 Macro SERIAL_ADD_SUB_SEG_EN defined: seg and sign_seg present, combinationally decoded from registered mag/neg; hex 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E; sign_seg = 0x3F (dash) when neg=1, else 0x7F (blank).
REQ-028 Macro undefined: seg and sign_seg ports and decode logic absent; all other behaviour identical.

Verification (WIDTH=4 unless stated)
REQ-029 SIGNED=0, a=9, b=8, sub=0, start 1 cycle -> busy 5 cycles, done at edge 5, mag=17, neg=0, ovf=1.
REQ-030 SIGNED=0, a=3, b=5, sub=1 -> mag=2, neg=1, ovf=1; a=5, b=3 -> mag=2, neg=0, ovf=0.
REQ-031 SIGNED=1, a=8 (-8), b=8 (-8), sub=0 -> mag=16, neg=1, ovf=1; a=7, b=15 (-1), sub=1 -> mag=8, neg=0, ovf=1.
REQ-032 start held high continuously -> back-to-back ops, done every 6 cycles; start pulses mid-CALC ignored.
REQ-033 rst_n low at cycle 2 of CALC -> all outputs 0 immediately, no done; next start (a=1, b=1, add) -> mag=2.
REQ-034 SEG_EN defined, result mag=17 neg=1 -> seg digit0=0x79, digit1=0x79, sign_seg=0x3F; after reset digits 0x40, sign_seg=0x7F.
